// File: rtl/alu_if.sv
// alu_if: operand/opcode bus into the ALU and its three registered result lanes.
interface alu_if;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [2:0]  funct3;
   logic        funct7;
   logic [31:0] adder_rsv;
   logic [31:0] shifter_rsv;
   logic [31:0] comparator_rsv;
   modport master (output op1, op2, funct3, funct7, input adder_rsv, shifter_rsv, comparator_rsv);
   modport slave  (input op1, op2, funct3, funct7, output adder_rsv, shifter_rsv, comparator_rsv);
endinterface

// File: rtl/alu.sv
// alu: RV32 integer ALU, one registered result per unit, only the funct3-selected unit nonzero.
module alu (
   input  logic  clk,
   input  logic  rst,
   alu_if.slave  bus_i
);
   logic [31:0] adder_d, adder_q, shifter_d, shifter_q, cmp_d, cmp_q;
   logic [4:0]  shamt;
   logic        lt_s, lt_u;
   always_comb begin
      shamt     = bus_i.op2[4:0];
      lt_s      = $signed(bus_i.op1) < $signed(bus_i.op2);
      lt_u      = bus_i.op1 < bus_i.op2;
      adder_d   = bus_i.funct3 == 3'b000 ? (bus_i.funct7 ? bus_i.op1 - bus_i.op2 : bus_i.op1 + bus_i.op2) :
                  bus_i.funct3 == 3'b100 ? bus_i.op1 ^ bus_i.op2 :
                  bus_i.funct3 == 3'b110 ? bus_i.op1 | bus_i.op2 :
                  bus_i.funct3 == 3'b111 ? bus_i.op1 & bus_i.op2 : 32'd0;
      shifter_d = bus_i.funct3 == 3'b001 ? bus_i.op1 << shamt :
                  bus_i.funct3 == 3'b101 ? (bus_i.funct7 ? $unsigned($signed(bus_i.op1) >>> shamt) : bus_i.op1 >> shamt) :
                  32'd0;
      cmp_d     = {31'd0, bus_i.funct3 == 3'b010 ? lt_s : bus_i.funct3 == 3'b011 ? lt_u : 1'b0};
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         adder_q   <= '0;
         shifter_q <= '0;
         cmp_q     <= '0;
      end else begin
         adder_q   <= adder_d;
         shifter_q <= shifter_d;
         cmp_q     <= cmp_d;
      end
   end
   assign bus_i.adder_rsv      = adder_q;
   assign bus_i.shifter_rsv    = shifter_q;
   assign bus_i.comparator_rsv = cmp_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench for alu; expected results queued at drive time, checked after the edge.
module tb_alu;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int tests = 0;
   int fails = 0;
   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] s;
      logic [31:0] c;
   } exp_t;
   exp_t sb[$];
   alu_if bus ();
   alu dut (.clk(clk), .rst(rst), .bus_i(bus));
   always #5 clk = ~clk;

   function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] f3, input logic f7);
      exp_t e;
      logic [63:0] ext;
      e.name = "rand";
      e.a = 0;
      e.s = 0;
      e.c = 0;
      ext = {{32{f7 & x[31]}}, x} >> y[4:0];
      case (f3)
         3'b000: e.a = f7 ? x + ~y + 32'd1 : x + y;
         3'b100: e.a = x ^ y;
         3'b110: e.a = x | y;
         3'b111: e.a = x & y;
         3'b001: e.s = x << y[4:0];
         3'b101: e.s = ext[31:0];
         3'b010: e.c = {31'd0, (x ^ 32'h8000_0000) < (y ^ 32'h8000_0000)};
         3'b011: e.c = {31'd0, x < y};
         default: ;
      endcase
      return e;
   endfunction

   task automatic check_out(input string name, input logic [31:0] a, input logic [31:0] s, input logic [31:0] c);
      tests += 3;
      if (bus.adder_rsv !== a) begin fails++; $display("FAIL %s adder got %h want %h", name, bus.adder_rsv, a); end
      if (bus.shifter_rsv !== s) begin fails++; $display("FAIL %s shifter got %h want %h", name, bus.shifter_rsv, s); end
      if (bus.comparator_rsv !== c) begin fails++; $display("FAIL %s comparator got %h want %h", name, bus.comparator_rsv, c); end
   endtask

   task automatic drive(input string name, input logic [31:0] x, input logic [31:0] y, input logic [2:0] f3, input logic f7,
                        input logic [31:0] a, input logic [31:0] s, input logic [31:0] c);
      exp_t e;
      bus.op1 = x;
      bus.op2 = y;
      bus.funct3 = f3;
      bus.funct7 = f7;
      e.name = name;
      e.a = a;
      e.s = s;
      e.c = c;
      sb.push_back(e);
   endtask

   task automatic step_check();
      exp_t e;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_out(e.name, e.a, e.s, e.c);
   endtask

   task automatic op(input string name, input logic [31:0] x, input logic [31:0] y, input logic [2:0] f3, input logic f7,
                     input logic [31:0] a, input logic [31:0] s, input logic [31:0] c);
      drive(name, x, y, f3, f7, a, s, c);
      step_check();
   endtask

   task automatic test_reset();
      bus.op1 = 32'd3;
      bus.op2 = 32'd4;
      bus.funct3 = 3'b000;
      bus.funct7 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_out("reset", 0, 0, 0);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      op("add100", 100, 100, 3'b000, 0, 200, 0, 0);
      op("sub100", 100, 100, 3'b000, 1, 0, 0, 0);
      op("xor100", 100, 100, 3'b100, 0, 0, 0, 0);
      op("or100",  100, 100, 3'b110, 1, 100, 0, 0);
      op("and100", 100, 100, 3'b111, 0, 100, 0, 0);
      op("sll100", 100, 100, 3'b001, 1, 0, 1600, 0);
      op("srl100", 100, 100, 3'b101, 0, 0, 6, 0);
      op("sra100", 100, 100, 3'b101, 1, 0, 6, 0);
      op("slt100", 100, 100, 3'b010, 0, 0, 0, 0);
      op("sltu100", 100, 100, 3'b011, 1, 0, 0, 0);
   endtask

   task automatic test_boundary();
      op("srl_neg", 32'hFFFF_FFF0, 4, 3'b101, 0, 0, 32'h0FFF_FFFF, 0);
      op("sra_neg", 32'hFFFF_FFF0, 4, 3'b101, 1, 0, 32'hFFFF_FFFF, 0);
      op("sll_neg", 32'hFFFF_FFF0, 4, 3'b001, 0, 0, 32'hFFFF_FF00, 0);
      op("slt_neg", 32'hFFFF_FFF0, 4, 3'b010, 0, 0, 0, 1);
      op("sltu_neg", 32'hFFFF_FFF0, 4, 3'b011, 0, 0, 0, 0);
      op("sub_wrap", 5, 7, 3'b000, 1, 32'hFFFF_FFFE, 0, 0);
      op("add_wrap", 32'hFFFF_FFFF, 1, 3'b000, 0, 0, 0, 0);
      op("sll_hi", 1, 32'h21, 3'b001, 0, 0, 2, 0);
      op("sll_zero", 1, 32'h20, 3'b001, 0, 0, 1, 0);
      op("sra_f7lo", 32'h8000_0000, 1, 3'b101, 0, 0, 32'h4000_0000, 0);
      op("slt_f7", 32'h8000_0000, 0, 3'b010, 1, 0, 0, 1);
      op("sltu_big", 0, 32'h8000_0000, 3'b011, 0, 0, 0, 1);
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic [31:0] x, y;
      logic [2:0] f3;
      logic f7;
      for (int i = 0; i < 200; i++) begin
         x = $urandom;
         y = (i % 4 == 0) ? x : $urandom;
         f3 = 3'($urandom_range(0, 7));
         f7 = 1'($urandom_range(0, 1));
         e = model(x, y, f3, f7);
         drive("b2b", x, y, f3, f7, e.a, e.s, e.c);
         step_check();
      end
   endtask

   task automatic test_reset_midstream();
      op("pre_rst_add", 3, 4, 3'b000, 0, 7, 0, 0);
      #2 rst = 1'b1;
      #1 check_out("async_rst", 0, 0, 0);
      bus.op1 = 32'd9;
      bus.funct3 = 3'b100;
      #1 rst = 1'b0;
      #1 check_out("rst_hold", 0, 0, 0);
      bus.op1 = 32'd3;
      bus.funct3 = 3'b000;
      drive("post_rst_add", 3, 4, 3'b000, 0, 7, 0, 0);
      step_check();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundary();
      test_back_to_back();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout tests %0d", tests);
      $fatal(1, "timeout");
   end
endmodule
